// File: rtl/router_pkg.sv
// Shared definitions for the router packet path: header field widths,
// the illegal destination code, transmitter states and the header packing.
package router_pkg;

  localparam int LEN_W  = 6;
  localparam int ADDR_W = 2;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_HEADER  = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_PARITY  = 3'd4,
    ST_GAP     = 3'd5
  } tx_state_t;

  function automatic logic [7:0] pack_header(input logic [LEN_W-1:0]  len_f,
                                             input logic [ADDR_W-1:0] dest_f);
    return {len_f, dest_f};
  endfunction

endpackage

// File: rtl/pkt_tx_buf.sv
// Payload store for one packet: synchronous write, asynchronous read so the
// transmitter can present buf[rcnt] in the same cycle the index changes.
module pkt_tx_buf #(
  parameter int DEPTH = 63,
  parameter int AW    = 6
) (
  input  logic          clock_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clock_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/router_pkt_tx.sv
// Store-and-forward transmitter: buffers a whole payload, then sends header,
// payload and parity to the router under busy flow control.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int MAX_LEN    = 63,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] dest,
  input  logic [LEN_W-1:0]  len,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              busy,
  output logic              pkt_valid,
  output logic [7:0]        pkt_data,
  output logic              ready,
  output logic              done,
  output logic              cfg_err
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  tx_state_t         state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [LEN_W-1:0]  wcnt_q, wcnt_d;
  logic [LEN_W-1:0]  rcnt_q, rcnt_d;
  logic [7:0]        parity_q, parity_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              done_q, done_d;
  logic              cfg_err_q, cfg_err_d;

  logic              buf_we;
  logic [7:0]        buf_rdata;

  pkt_tx_buf #(
    .DEPTH (MAX_LEN),
    .AW    (LEN_W)
  ) u_buf (
    .clock_i (clock),
    .we_i    (buf_we),
    .waddr_i (wcnt_q),
    .wdata_i (wr_data),
    .raddr_i (rcnt_q),
    .rdata_o (buf_rdata)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    dest_d    = dest_q;
    wcnt_d    = wcnt_q;
    rcnt_d    = rcnt_q;
    parity_d  = parity_q;
    gap_d     = gap_q;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;
    buf_we    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if ((len != '0) && (dest != ADDR_INVALID)) begin
            len_d    = len;
            dest_d   = dest;
            parity_d = pack_header(len, dest);
            wcnt_d   = '0;
            rcnt_d   = '0;
            state_d  = ST_LOAD;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      ST_LOAD: begin
        if (wr_en) begin
          buf_we   = 1'b1;
          parity_d = parity_q ^ wr_data;
          wcnt_d   = wcnt_q + 6'd1;
          if (wcnt_q == len_q - 6'd1) begin
            state_d = ST_HEADER;
          end
        end
      end

      ST_HEADER: begin
        if (!busy) begin
          state_d = ST_PAYLOAD;
        end
      end

      ST_PAYLOAD: begin
        // The byte at rcnt stays on the bus until the router takes it.
        if (!busy) begin
          if (rcnt_q == len_q - 6'd1) begin
            state_d = ST_PARITY;
          end else begin
            rcnt_d = rcnt_q + 6'd1;
          end
        end
      end

      ST_PARITY: begin
        if (!busy) begin
          done_d  = 1'b1;
          gap_d   = '0;
          state_d = ST_GAP;
        end
      end

      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      dest_q    <= '0;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      parity_q  <= '0;
      gap_q     <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      dest_q    <= dest_d;
      wcnt_q    <= wcnt_d;
      rcnt_q    <= rcnt_d;
      parity_q  <= parity_d;
      gap_q     <= gap_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Outputs decode registered state only; busy/start/wr_en never reach them.
  always_comb begin
    pkt_data = 8'h00;
    case (state_q)
      ST_HEADER:  pkt_data = pack_header(len_q, dest_q);
      ST_PAYLOAD: pkt_data = buf_rdata;
      ST_PARITY:  pkt_data = parity_q;
      default:    pkt_data = 8'h00;
    endcase
  end

  assign pkt_valid = (state_q == ST_HEADER) || (state_q == ST_PAYLOAD);
  assign ready     = (state_q == ST_IDLE);
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Randomized scoreboard bench: stimulus pushes the expected byte stream of
// each packet, a negedge monitor pops one entry per byte the router consumes.
module tb_router_pkt_tx;

  localparam int GAP_CYCLES = 2;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [1:0] dest = 2'd0;
  logic [5:0] len = 6'd0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       busy = 1'b0;
  logic       pkt_valid;
  logic [7:0] pkt_data;
  logic       ready;
  logic       done;
  logic       cfg_err;

  router_pkt_tx #(.MAX_LEN(63), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .dest      (dest),
    .len       (len),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .busy      (busy),
    .pkt_valid (pkt_valid),
    .pkt_data  (pkt_data),
    .ready     (ready),
    .done      (done),
    .cfg_err   (cfg_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    bit         is_par;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] pl [64];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] last_par = 8'h00;
  bit         exp_par = 1'b0;
  bit         exp_done = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference model: a packet is its header, its payload bytes, then the XOR of all of them.
  task automatic push_pkt(input logic [1:0] d, input logic [5:0] l, input int off);
    logic [7:0] par;
    exp_t       e;
    par = {l, d};
    e.data = par; e.is_par = 1'b0; sb.push_back(e);
    for (int i = 0; i < int'(l); i++) begin
      e.data = pl[off + i]; e.is_par = 1'b0; sb.push_back(e);
      par = par ^ pl[off + i];
    end
    e.data = par; e.is_par = 1'b1; sb.push_back(e);
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (!resetn) begin
      sb.delete();
      exp_par  = 1'b0;
      exp_done = 1'b0;
    end else begin
      if (exp_done) begin
        chk("done_pulse", done, 1);
        exp_done = 1'b0;
      end else begin
        chk("done_idle", done, 0);
      end
      if (pkt_valid) begin
        if (exp_par) begin
          checks++; errors++;
          $display("FAIL valid_in_parity: pkt_valid=1 data=0x%0h, parity phase expected", pkt_data);
        end else if (!busy) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_byte: got 0x%0h, no byte expected", pkt_data);
          end else begin
            e = sb.pop_front();
            chk("payload_byte", pkt_data, e.data);
            chk("payload_kind", e.is_par, 0);
            if (sb.size() > 0 && sb[0].is_par) exp_par = 1'b1;
          end
        end
      end else if (exp_par && !busy) begin
        e = sb.pop_front();
        chk("parity_byte", pkt_data, e.data);
        last_par = pkt_data;
        exp_par  = 1'b0;
        exp_done = 1'b1;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 300) begin @(posedge clock); #1; n++; end
    chk("ready_wait", ready, 1);
  endtask

  // mode 0: busy low; 1: random busy and write gaps; 2: stall on byte 0x02; 3: reset at payload byte 3
  task automatic run_pkt(input logic [1:0] d, input logic [5:0] l, input int mode,
                         output logic [7:0] hdr_seen, output int hold02);
    int n;
    int hold_left;
    bit got_done;
    wait_ready();
    start = 1'b1; dest = d; len = l; busy = 1'b0;
    push_pkt(d, l, 0);
    @(posedge clock); #1;
    start = 1'b0;
    chk("ready_in_load", ready, 0);
    for (int i = 0; i < int'(l); i++) begin
      if (mode == 1) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
        busy = ($urandom_range(0, 1) == 0);
      end
      wr_en = 1'b1; wr_data = pl[i];
      @(posedge clock); #1;
      wr_en = 1'b0;
    end
    chk("hdr_latency", pkt_valid, 1);
    hdr_seen  = pkt_data;
    hold02    = 0;
    hold_left = 3;
    got_done  = 1'b0;
    n = 0;
    while (!got_done && n < 800) begin
      busy = 1'b0;
      if (mode == 1) busy = ($urandom_range(0, 2) == 0);
      if (mode == 2 && pkt_valid && pkt_data == 8'h02) begin
        hold02++;
        if (hold_left > 0) begin busy = 1'b1; hold_left--; end
      end
      if (mode == 3 && pkt_valid && pkt_data == pl[3] && n > 0) begin
        resetn = 1'b0;
        #1;
        chk("rst_valid", pkt_valid, 0);
        chk("rst_data", pkt_data, 8'h00);
        chk("rst_ready", ready, 1);
        break;
      end
      @(posedge clock); #1;
      n++;
      if (done) got_done = 1'b1;
    end
    busy = 1'b0;
    if (mode != 3) begin
      chk("done_seen", got_done, 1);
      n = 0;
      while (!ready && n < 20) begin @(posedge clock); #1; n++; end
      chk("gap_cycles", n, GAP_CYCLES);
    end
    $display("pkt dest=%0d len=%0d mode=%0d hdr=0x%0h par=0x%0h", d, l, mode, hdr_seen, last_par);
  endtask

  task automatic bad_req(input logic [1:0] d, input logic [5:0] l);
    start = 1'b1; dest = d; len = l;
    @(posedge clock); #1;
    start = 1'b0;
    chk("cfg_err_pulse", cfg_err, 1);
    chk("cfg_err_ready", ready, 1);
    @(posedge clock); #1;
    chk("cfg_err_clear", cfg_err, 0);
    chk("cfg_err_valid", pkt_valid, 0);
    $display("bad request dest=%0d len=%0d", d, l);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] hdr;
    logic [7:0] x;
    int         h02;
    int         n;
    int         p_cyc;
    int         h_cyc;

    #2;
    chk("reset_ready", ready, 1);
    chk("reset_valid", pkt_valid, 0);
    chk("reset_data", pkt_data, 8'h00);
    chk("reset_done", done, 0);
    chk("reset_cfg_err", cfg_err, 0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    resetn = 1'b1;

    // Directed packet, no back-pressure
    for (int i = 0; i < 5; i++) pl[i] = 8'(i + 1);
    run_pkt(2'd2, 6'd5, 0, hdr, h02);
    chk("hdr_16", hdr, 8'h16);
    chk("par_17", last_par, 8'h17);

    // Same packet with the router stalling on byte 0x02
    run_pkt(2'd2, 6'd5, 2, hdr, h02);
    chk("hold02_cycles", h02, 4);
    chk("par_17_stall", last_par, 8'h17);

    bad_req(2'd1, 6'd0);
    bad_req(2'd3, 6'd7);

    // Maximum length, incrementing payload
    x = 8'h00;
    for (int i = 0; i < 63; i++) begin pl[i] = 8'(i); x = x ^ 8'(i); end
    run_pkt(2'd0, 6'd63, 0, hdr, h02);
    chk("hdr_fc", hdr, 8'hFC);
    chk("par_63", last_par, 8'hFC ^ x);

    // Reset while payload byte 3 is on the bus, then a clean packet
    for (int i = 0; i < 14; i++) pl[i] = 8'(8'h40 + i);
    run_pkt(2'd2, 6'd8, 3, hdr, h02);
    @(posedge clock); #1;
    @(posedge clock); #1;
    resetn = 1'b1;
    run_pkt(2'd1, 6'd14, 0, hdr, h02);
    chk("hdr_39", hdr, 8'h39);

    // Back-to-back requests with start held high
    pl[0] = 8'hA1; pl[1] = 8'hB2; pl[10] = 8'hC3;
    wait_ready();
    start = 1'b1; dest = 2'd1; len = 6'd2;
    push_pkt(2'd1, 6'd2, 0);
    @(posedge clock); #1;
    dest = 2'd2; len = 6'd1;
    push_pkt(2'd2, 6'd1, 10);
    for (int i = 0; i < 2; i++) begin
      wr_en = 1'b1; wr_data = pl[i];
      @(posedge clock); #1;
      wr_en = 1'b0;
    end
    n = 0;
    while (!done && n < 50) begin @(posedge clock); #1; n++; end
    chk("b2b_done_a", done, 1);
    p_cyc = cyc;
    wait_ready();
    @(posedge clock); #1;
    start = 1'b0;
    chk("b2b_accept", ready, 0);
    wr_en = 1'b1; wr_data = pl[10];
    @(posedge clock); #1;
    wr_en = 1'b0;
    h_cyc = cyc;
    chk("b2b_hdr_valid", pkt_valid, 1);
    chk("b2b_hdr", pkt_data, 8'h06);
    chk("b2b_spacing_ok", ((h_cyc - p_cyc) >= GAP_CYCLES + 1) ? 1 : 0, 1);
    n = 0;
    while (!done && n < 50) begin @(posedge clock); #1; n++; end
    chk("b2b_done_b", done, 1);
    $display("back-to-back: parity consumed at cycle %0d, next header at cycle %0d", p_cyc, h_cyc);

    // Randomized packets under random back-pressure
    for (int k = 0; k < 8; k++) begin
      logic [1:0] rd;
      logic [5:0] rl;
      rd = 2'($urandom_range(0, 2));
      rl = 6'($urandom_range(1, 63));
      for (int i = 0; i < 63; i++) pl[i] = 8'($urandom_range(0, 255));
      run_pkt(rd, rl, 1, hdr, h02);
      chk("rand_hdr", hdr, {rl, rd});
    end

    repeat (4) begin @(posedge clock); #1; end
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
Store-and-forward packet transmitter that drives the 1x3 router's input port (pkt_valid, data_in, busy).
- Accepts a packet request (destination, length) and the payload bytes over a local write port, buffering the payload internally.
- Emits header, payload and parity back-to-back under router busy flow control.
- Sits in front of the router, replacing bench-driven stimulus in system builds.

Parameters:
MAX_LEN, 63, maximum payload length in bytes; fixed by the 6-bit header length field.
GAP_CYCLES, 2, idle cycles enforced after parity before the next request is accepted.

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  request strobe; sampled only in IDLE
dest  in  2  destination port 0..2; 3 is illegal
len  in  6  payload length 1..63; 0 is illegal
wr_en  in  1  payload byte write strobe; honoured only in LOAD
wr_data  in  8  payload byte
busy  in  1  router busy; a driven byte is consumed at a rising edge only when busy==0
pkt_valid  out  1  to router pkt_valid
pkt_data  out  8  to router data_in
ready  out  1  high in IDLE
done  out  1  one-cycle pulse when parity is consumed
cfg_err  out  1  one-cycle pulse on an illegal request

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, pkt_valid=0, pkt_data=0x00, done=0, cfg_err=0, ready=1.
  - Counters and parity are cleared.
  - Asserting reset mid-packet drops pkt_valid immediately and discards the packet.
- Outputs are Moore-only: functions of registered state, index and buffer. There is no combinational path from busy, start or wr_en to any output.
- FSM states: IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP.
- IDLE:
  - start=1 with len!=0 and dest!=3 latches len/dest and moves to LOAD next cycle.
  - parity is initialised to header = {len,dest}.
  - An illegal request pulses cfg_err next cycle and stays in IDLE.
- LOAD:
  - Each wr_en writes wr_data to buf[wcnt], increments wcnt and XORs the byte into parity.
  - Gaps between writes are allowed.
  - The edge that writes byte len-1 moves the FSM to HEADER.
  - start is ignored.
- HEADER: pkt_valid=1, pkt_data={len,dest}. Advances to PAYLOAD at the first edge with busy==0.
- PAYLOAD:
  - pkt_valid=1, pkt_data=buf[rcnt].
  - rcnt increments only at edges with busy==0; otherwise the byte is held.
  - Consuming byte len-1 moves the FSM to PARITY.
- PARITY:
  - pkt_valid=0, pkt_data=parity.
  - Held until an edge with busy==0, which pulses done the next cycle and moves to GAP.
- GAP: pkt_valid=0, pkt_data=0x00 for GAP_CYCLES cycles, then IDLE.
- Parity is the 8-bit XOR of the header and all payload bytes.
- Latency:
  - First header cycle is 1 cycle after the last payload write.
  - With busy held low, a packet occupies len+2 cycles on the router interface.
- wr_en outside LOAD and start outside IDLE are ignored silently.
- wcnt and rcnt are 6 bits; no wrap is possible because both are bounded by len<=63.

Decomposition:
- Shared package router_pkg:
  - Header field widths: LEN_W=6, ADDR_W=2.
  - ADDR_INVALID=2'b11.
  - Tx state enum.
  - Header pack function {len,dest}.
- Sub-module pkt_tx_buf: MAX_LEN x 8 payload RAM with synchronous write and asynchronous read, instantiated once.

Test Plan:
- dest=2, len=5, payload 01..05, busy=0 -> header 0x16, then 01,02,03,04,05 with pkt_valid=1, then parity 0x17 with pkt_valid=0, done pulses, ready returns after 2 GAP cycles.
- Same packet with busy=1 for 3 cycles while payload byte 0x02 is driven -> 0x02 held 4 cycles, no byte skipped or duplicated, parity still 0x17.
- start with len=0, then start with dest=3 -> one cfg_err pulse each, pkt_valid never asserts, stays in IDLE.
- dest=0, len=63, incrementing payload 00..3E -> header 0xFC, 63 payload bytes in order, parity 0xFC XOR (XOR of 00..3E).
- resetn pulsed low while payload byte 3 is driven -> pkt_valid=0 and pkt_data=0x00 immediately; a new dest=1, len=14 packet then transmits correctly with header 0x39.
- Two back-to-back requests with start held high -> second header appears no earlier than GAP_CYCLES+1 cycles after the first parity is consumed.
